// File: rtl/sio_pkg.sv
// ---------------------------------------------------------------------------
// sio_pkg
// Shared definitions for the SIO link receive/transmit blocks.
//   CRC16_POLY : CRC-16 polynomial x^16+x^15+x^2+1 (normal form, 16'h8005)
//   CRC16_INIT : CRC register value at the start of every frame
//   state_t    : deframer FSM state encoding (IDLE, BODY, CHECK)
// ---------------------------------------------------------------------------
package sio_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/sio_deframer_crc16_nw.sv
// ---------------------------------------------------------------------------
// crc16_nw
// Combinational CRC-16 step over an NW-bit nibble; d[0] is folded in first.
// Shared between the SIO deframer (receive) and framer (transmit).
// Ports:
//   crc_in  [15:0]   : CRC register before this nibble
//   d       [NW-1:0] : nibble, bit 0 earliest on the wire
//   crc_out [15:0]   : CRC register after folding in all NW bits
// ---------------------------------------------------------------------------
module crc16_nw
    import sio_pkg::*;
#(
    parameter int NW = 4
) (
    input  logic [15:0]   crc_in,
    input  logic [NW-1:0] d,
    output logic [15:0]   crc_out
);

    logic [15:0] acc;

    always_comb begin
        acc = crc_in;
        for (int i = 0; i < NW; i++) begin
            if (acc[15] ^ d[i]) begin
                acc = {acc[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                acc = {acc[14:0], 1'b0};
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/sio_deframer.sv
// ---------------------------------------------------------------------------
// sio_deframer
// Receive-side deframer for the SIO serial link. Finds the start nibble
// (all zeros), assembles payload and stream fields LSB first, checks the
// CRC-16 carried in the trailing 16 bits and presents the frame with a
// one-cycle valid strobe.
//
// Frame on the wire (one nibble per accepted ce):
//   start (d == 0) | PBITS payload | SBITS stream | 16-bit CRC, all LSB first
// The top SNC stream bits are not covered by the CRC; the start nibble is
// not covered either.
//
// Handshake: ce is a qualifier with no backpressure; a nibble is consumed
// on every rising c edge where ce is high, and nothing moves while ce is
// low. valid is a one-cycle strobe with no ready; payload, stream and
// crc_ok belong to that strobe and hold until the next one.
//
// Ports:
//   c        : link clock
//   rn       : asynchronous active-low reset
//   ce       : nibble valid
//   d        : received nibble
//   errclr   : synchronous clear of errcnt
//   valid    : frame complete strobe
//   crc_ok   : CRC check result, qualified by valid
//   payload  : last frame payload, bit 0 first received
//   stream   : last frame stream bits
//   errcnt   : CRC error count
//   dbg_state: current FSM state, for observation only
//
// Build option: define SIO_DEFRAMER_ERRCNT_EN to build the saturating CRC
// error counter; otherwise errcnt is tied to zero and errclr is ignored.
// ---------------------------------------------------------------------------
module sio_deframer
    import sio_pkg::*;
#(
    parameter int NW    = 4,
    parameter int PBITS = 80,
    parameter int SBITS = 16,
    parameter int SNC   = 4
) (
    input  logic             c,
    input  logic             rn,
    input  logic             ce,
    input  logic [NW-1:0]    d,
    input  logic             errclr,
    output logic             valid,
    output logic             crc_ok,
    output logic [PBITS-1:0] payload,
    output logic [SBITS-1:0] stream,
    output logic [15:0]      errcnt,
    output state_t           dbg_state
);

    localparam int TOT     = PBITS + SBITS;
    localparam int FRAME_N = TOT / NW;
    localparam int CRC_N   = 16 / NW;
    localparam int CW      = $clog2(FRAME_N + 1);

    localparam logic [CW-1:0] BODY_LAST  = CW'(FRAME_N - 1);
    localparam logic [CW-1:0] CHECK_LAST = CW'(CRC_N - 1);
    // Body nibbles with an index below this are folded into the CRC.
    localparam logic [CW-1:0] CRC_STOP   = CW'((TOT - SNC) / NW);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [15:0]      crc_q, crc_next;
    logic [15:0]      rx_q, rx_next;
    logic [TOT-1:0]   sh_q, sh_next;
    logic             take_start, take_body, take_crc;
    logic             body_last, frame_done;

    // Shifting in at the MSB end leaves the first received bit at bit 0.
    logic [TOT+NW-1:0] sh_wide;
    logic [15+NW:0]    rx_wide;
    assign sh_wide = {d, sh_q};
    assign rx_wide = {d, rx_q};
    assign sh_next = sh_wide[TOT+NW-1:NW];
    assign rx_next = rx_wide[15+NW:NW];

    crc16_nw #(.NW(NW)) u_crc (
        .crc_in  (crc_q),
        .d       (d),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        take_body  = 1'b0;
        take_crc   = 1'b0;
        body_last  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce && (d == '0)) begin
                    take_start = 1'b1;
                    state_d    = BODY;
                end
            end
            BODY: begin
                if (ce) begin
                    take_body = 1'b1;
                    if (cnt_q == BODY_LAST) begin
                        body_last = 1'b1;
                        state_d   = CHECK;
                    end
                end
            end
            CHECK: begin
                if (ce) begin
                    take_crc = 1'b1;
                    if (cnt_q == CHECK_LAST) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC16_INIT;
            rx_q    <= '0;
            sh_q    <= '0;
            valid   <= 1'b0;
            crc_ok  <= 1'b0;
            payload <= '0;
            stream  <= '0;
        end else begin
            state_q <= state_d;
            valid   <= frame_done;
            if (take_start) begin
                cnt_q <= '0;
                crc_q <= CRC16_INIT;
            end
            if (take_body) begin
                sh_q  <= sh_next;
                cnt_q <= body_last ? '0 : cnt_q + CW'(1);
                if (cnt_q < CRC_STOP) begin
                    crc_q <= crc_next;
                end
            end
            if (take_crc) begin
                rx_q  <= rx_next;
                cnt_q <= cnt_q + CW'(1);
            end
            if (frame_done) begin
                crc_ok  <= (rx_next == crc_q);
                payload <= sh_q[PBITS-1:0];
                stream  <= sh_q[TOT-1:PBITS];
            end
        end
    end

    assign dbg_state = state_q;

`ifdef SIO_DEFRAMER_ERRCNT_EN
    logic [15:0] errcnt_q;

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            errcnt_q <= '0;
        end else if (errclr) begin
            errcnt_q <= '0;
        end else if (valid && !crc_ok && (errcnt_q != 16'hFFFF)) begin
            errcnt_q <= errcnt_q + 16'd1;
        end
    end

    assign errcnt = errcnt_q;
`else
    logic unused_errclr;
    assign unused_errclr = errclr;
    assign errcnt        = '0;
`endif

endmodule

// File: tb/tb_sio_deframer.sv
module tb_sio_deframer;
    import sio_pkg::*;

    localparam int NW      = 4;
    localparam int PBITS   = 80;
    localparam int SBITS   = 16;
    localparam int SNC     = 4;
    localparam int TOT     = PBITS + SBITS;
    localparam int FRAME_N = TOT / NW;
    localparam int CRC_N   = 16 / NW;
    localparam int W       = TOT + 1;

    // ---------------- clock / reset ----------------
    logic             c = 1'b0;
    logic             rn = 1'b0;
    logic             ce = 1'b0;
    logic [NW-1:0]    d = '1;
    logic             errclr = 1'b0;
    logic             valid;
    logic             crc_ok;
    logic [PBITS-1:0] payload;
    logic [SBITS-1:0] stream;
    logic [15:0]      errcnt;
    state_t           dbg_state;

    always #4 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    sio_deframer #(.NW(NW), .PBITS(PBITS), .SBITS(SBITS), .SNC(SNC)) dut (
        .c         (c),
        .rn        (rn),
        .ce        (ce),
        .d         (d),
        .errclr    (errclr),
        .valid     (valid),
        .crc_ok    (crc_ok),
        .payload   (payload),
        .stream    (stream),
        .errcnt    (errcnt),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference CRC: straight from the bit-serial rule over the frame bits,
    // first wire bit first, skipping the top SNC stream bits.
    function automatic logic [15:0] ref_crc(input logic [PBITS-1:0] p, input logic [SBITS-1:0] s);
        logic [TOT-1:0] f;
        logic [15:0]    r;
        f = {s, p};
        r = 16'hFFFF;
        for (int i = 0; i < TOT - SNC; i++) begin
            if (r[15] ^ f[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge c) begin
        if (rn && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                logic [W-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("valid_cycle", 128'(cyc), 128'(ec));
                chk("payload", 128'(payload), 128'(e[PBITS-1:0]));
                chk("stream", 128'(stream), 128'(e[TOT-1:PBITS]));
                chk("crc_ok", 128'(crc_ok), 128'(e[TOT]));
`ifdef SIO_DEFRAMER_ERRCNT_EN
                if (!e[TOT] && exp_err < 65535) exp_err++;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_nib(input logic [NW-1:0] v, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            @(negedge c);
            ce = 1'b0;
            d  = NW'($urandom);
        end
        @(negedge c);
        ce = 1'b1;
        d  = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge c);
            ce = 1'b1;
            d  = NW'($urandom_range(1, (1 << NW) - 1));
        end
        @(negedge c);
        ce = 1'b0;
        d  = '1;
    endtask

    task automatic send_frame(input logic [PBITS-1:0] p, input logic [SBITS-1:0] s,
                              input logic [15:0] crc, input int gap_pct);
        logic [TOT-1:0] f;
        f = {s, p};
        drive_nib('0, gap_pct);
        for (int i = 0; i < FRAME_N; i++) drive_nib(f[i*NW +: NW], gap_pct);
        for (int j = 0; j < CRC_N; j++) begin
            drive_nib(crc[j*NW +: NW], gap_pct);
            if (j == CRC_N - 1) begin
                exp_q.push_back({(ref_crc(p, s) == crc), s, p});
                exp_cyc_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge c);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge c);
        chk("errcnt", 128'(errcnt), 128'(exp_err));
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_crc_ok", 128'(crc_ok), 128'(0));
        chk("rst_payload", 128'(payload), 128'(0));
        chk("rst_stream", 128'(stream), 128'(0));
        chk("rst_errcnt", 128'(errcnt), 128'(0));
        chk("rst_state", 128'(dbg_state), 128'(IDLE));
    endtask

    function automatic logic [PBITS-1:0] rand_payload();
        logic [PBITS-1:0] p;
        for (int i = 0; i < PBITS; i++) p[i] = 1'($urandom_range(1));
        return p;
    endfunction

    // ---------------- stimulus ----------------
    logic [PBITS-1:0] p0;
    logic [SBITS-1:0] s0;
    logic [15:0]      crc0;

    initial begin
        p0   = 80'h0123456789ABCDEF_1234;
        s0   = 16'hA55A;
        crc0 = ref_crc(p0, s0);

        repeat (3) @(negedge c);
        check_reset_outputs();
        rn = 1'b1;
        idle(3);

        // Good frame with the reference CRC.
        send_frame(p0, s0, crc0, 0);
        idle(2);
        drain();

        // Payload bit 17 flipped, original CRC.
        send_frame(p0 ^ (80'd1 << 17), s0, crc0, 0);
        idle(2);
        drain();

        // Only the CRC-excluded stream bits change.
        send_frame(p0, {4'h3, s0[11:0]}, crc0, 0);
        idle(2);
        drain();

        // Same frame with 50% ce gaps.
        send_frame(p0, s0, crc0, 50);
        idle(1);
        drain();

        // Back-to-back frames, then a third one aborted by reset at nibble 10.
        send_frame(p0, s0, crc0, 0);
        send_frame(~p0, 16'h1234, ref_crc(~p0, 16'h1234), 0);
        drain();
        drive_nib('0, 0);
        for (int i = 0; i < 10; i++) drive_nib(NW'($urandom), 0);
        @(negedge c);
        ce = 1'b0;
        rn = 1'b0;
        exp_err = 0;
        #1;
        check_reset_outputs();
        @(negedge c);
        rn = 1'b1;
        send_frame(p0, s0, crc0, 0);
        idle(2);
        drain();

        // Randomized frames: random fields, random gaps, some bad CRCs,
        // sometimes back-to-back.
        for (int k = 0; k < 24; k++) begin
            logic [PBITS-1:0] p;
            logic [SBITS-1:0] s;
            logic [15:0]      cr;
            p  = rand_payload();
            s  = SBITS'($urandom);
            cr = ref_crc(p, s);
            if ($urandom_range(3) == 0) cr = cr ^ (16'd1 << $urandom_range(15));
            send_frame(p, s, cr, int'($urandom_range(0, 40)));
            if ($urandom_range(1) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(1);
        drain();

        // Error counter clear.
        @(negedge c);
        errclr = 1'b1;
        @(negedge c);
        errclr  = 1'b0;
        exp_err = 0;
        @(negedge c);
        chk("errcnt_clr", 128'(errcnt), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sio_deframer.md
# sio_deframer

Parametrised receive-side deframer for the SIO serial link. Takes the per-cycle nibble stream produced by the SIO DDR front end, finds the start of each frame, shifts in payload and stream fields LSB first, computes and checks the CRC-16 (x^16+x^15+x^2+1) over an NW-bit datapath, and presents a whole frame with a one-cycle valid strobe. Sits between the SIO PHY (`rd` nibble output) and the register/stream logic. One instance serves host-side (PBITS=80) and target-side (PBITS=32) links.

## Interface
- NW, 4: bits per accepted nibble; must divide PBITS, SBITS, SNC and 16
- PBITS, 80: payload bits after start nibble (80 = 16 addr + 64 data; 32 on target side)
- SBITS, 16: stream bits following payload
- SNC, 4: most-significant stream bits excluded from CRC (0 ≤ SNC ≤ SBITS)

- c  in  1  link clock (125 MHz)
- rn  in  1  reset, asynchronous assert, active-low
- ce  in  1  nibble valid; state advances only when high
- d  in  NW  received nibble, bit 0 earliest on the wire
- errclr  in  1  clear error counter (see Configuration)
- valid  out  1  one-cycle strobe: frame complete
- crc_ok  out  1  CRC check result, qualified by valid
- payload  out  PBITS  last frame payload, bit 0 first received
- stream  out  SBITS  last frame stream bits
- errcnt  out  16  CRC error count

## Operation
- Line idles high; start nibble is d == 0 (all NW bits zero), not covered by CRC.
- States: IDLE, BODY, CHECK.
- IDLE: ce && d==0 -> BODY, nibble counter = 0, CRC register = 16'hFFFF. Other nibbles ignored.
- BODY: each ce shifts d into a (PBITS+SBITS)-bit shift register at the MSB end (LSB-first assembly); CRC updated unless nibble lies in top SNC stream bits. After (PBITS+SBITS)/NW nibbles -> CHECK.
- CHECK: 16/NW nibbles shifted into received-CRC register, LSB first. On last one -> IDLE, set valid next cycle.
- CRC step, per bit b, b = d[0] first: fb = crc[15]^b; crc = {crc[14:0],0} ^ (fb ? 16'h8005 : 0). All NW bits folded combinationally in one cycle.
- crc_ok = (received CRC == computed CRC).
- payload/stream update only with valid; hold between frames.
- Counter width: clog2((PBITS+SBITS)/NW + 1), saturating is not needed; wraps only via state change.

## Timing
- Reset values: valid=0, crc_ok=0, payload=0, stream=0, errcnt=0, state IDLE, CRC=16'hFFFF.
- Latency: valid, crc_ok, payload, stream registered; valid high exactly one cycle after the c edge accepting the last CRC nibble.
- ce low mid-frame: state, counter, CRC hold; no timeout.
- Back-to-back: start nibble may be accepted in the cycle valid is high (zero idle nibbles between frames).
- Start nibble arriving mid-frame is treated as data.
- rn low mid-frame: immediate return to IDLE, partial frame discarded, no valid.

## Configuration
- SIO_DEFRAMER_ERRCNT_EN defined: errcnt increments (saturating at 16'hFFFF) on each valid with crc_ok=0; errclr synchronous clear, takes priority over same-cycle increment.
- Undefined: errcnt tied to 0, errclr ignored; no counter logic.

## Structure
- Package sio_pkg: CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, state enum (IDLE, BODY, CHECK).
- Sub-module crc16_nw (parameter NW): combinational NW-bit CRC step, crc_in + d -> crc_out; reused by future SIO framer (transmit side).

## Test plan
- Reset: assert rn mid-simulation -> all outputs 0, next start nibble begins fresh frame.
- Good frame, defaults: 0x0, payload 80'h0123456789ABCDEF_1234, stream 16'hA55A, correct CRC from reference model -> valid one cycle after 28th post-start nibble, crc_ok=1, fields match.
- Corrupt frame: same frame, payload bit 17 flipped -> valid, crc_ok=0, errcnt=1 (macro on) / 0 (macro off).
- SNC exclusion: change stream[15:12] only, original CRC -> crc_ok=1.
- ce gaps: ce low on random 50% of cycles -> identical results, valid delayed accordingly.
- Back-to-back + mid-frame reset: two frames with zero gap -> two valid strobes 29 cycles apart; rn pulse at nibble 10 of third -> no valid, following frame correct.
